// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions: operand-select codes, hazard shadow-slot type,
// and the zero-register constant. The EX stage imports this package as well.
package pipe_pkg;

    // EX operand-select codes. The value 2'b11 is reserved and never driven.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // register-file read data
        FWD_MEM = 2'b01,  // MEM-stage result (DataMemWB port)
        FWD_WB  = 2'b10   // WB-stage result (WriteBackWB port)
    } fwd_sel_e;

    // X31 reads as zero and is never a forwarding source.
    localparam logic [4:0] XZR = 5'd31;

    // Shadow copy of the write-back information of one in-flight instruction.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{rd: XZR, reg_write: 1'b0, mem_read: 1'b0};

    // Priority select: the newer producer (EX slot) beats the older one (MEM slot).
    // A load sitting in the MEM slot delivers its data on the memory-data path,
    // so a reader that waited out a load-use stall takes it through FWD_MEM.
    function automatic fwd_sel_e pick_sel(input logic hit_ex,
                                          input logic hit_mem,
                                          input logic mem_is_load);
        if (hit_ex)       return FWD_MEM;
        else if (hit_mem) return mem_is_load ? FWD_MEM : FWD_WB;
        else              return FWD_REG;
    endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// ID-stage hazard bus: source/destination info in, forwarding and stall out.
interface forward_hazard_unit_if;

    logic [4:0] RnID;
    logic [4:0] RmID;
    logic       UsesRnID;
    logic       UsesRmID;
    logic [4:0] WriteRegID;
    logic       RegWriteRegisterID;
    logic       MemReadRegisterID;
    logic       FlushID;
    logic [1:0] ForwCntrl1;
    logic [1:0] ForwCntrl2;
    logic       StallID;
    logic       BubbleEX;

    // Pipeline side: presents the ID instruction, consumes selects and stall.
    modport master (
        output RnID, RmID, UsesRnID, UsesRmID, WriteRegID,
               RegWriteRegisterID, MemReadRegisterID, FlushID,
        input  ForwCntrl1, ForwCntrl2, StallID, BubbleEX
    );

    // Hazard unit side.
    modport slave (
        input  RnID, RmID, UsesRnID, UsesRmID, WriteRegID,
               RegWriteRegisterID, MemReadRegisterID, FlushID,
        output ForwCntrl1, ForwCntrl2, StallID, BubbleEX
    );

endinterface

// File: rtl/forward_hazard_unit_fwd_compare.sv
// One source-vs-producer comparator: true when the source is actually read,
// the slot writes a register, and that register is the source (never XZR).
module fwd_compare
    import pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       use_i,
    input  slot_t      slot_i,
    output logic       match_o
);

    assign match_o = use_i && slot_i.reg_write
                     && (slot_i.rd == src_i) && (slot_i.rd != XZR);

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit. Tracks EX/MEM/WB destinations in shadow
// slots, registers the EX operand selects one cycle ahead, and raises a
// combinational stall for load-use hazards.
module forward_hazard_unit
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    forward_hazard_unit_if.slave bus
);

    slot_t    ex_q, mem_q, wb_q;
    slot_t    ex_d;
    fwd_sel_e fwd1_q, fwd1_d;
    fwd_sel_e fwd2_q, fwd2_d;
    logic     bubble_q, bubble_d;

    logic     rn_hit_ex, rn_hit_mem, rm_hit_ex, rm_hit_mem;
    logic     stall, squash;

    fwd_compare u_rn_ex  (.src_i(bus.RnID), .use_i(bus.UsesRnID), .slot_i(ex_q),  .match_o(rn_hit_ex));
    fwd_compare u_rn_mem (.src_i(bus.RnID), .use_i(bus.UsesRnID), .slot_i(mem_q), .match_o(rn_hit_mem));
    fwd_compare u_rm_ex  (.src_i(bus.RmID), .use_i(bus.UsesRmID), .slot_i(ex_q),  .match_o(rm_hit_ex));
    fwd_compare u_rm_mem (.src_i(bus.RmID), .use_i(bus.UsesRmID), .slot_i(mem_q), .match_o(rm_hit_mem));

    // Hazard detection and next-state selection for the EX slot and selects.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stall  = 1'b0;
        squash = 1'b0;
        ex_d   = SLOT_BUBBLE;
        fwd1_d = FWD_REG;
        fwd2_d = FWD_REG;

        // Load in EX feeding a used source; the comparators already exclude XZR.
        // Held low while reset is asserted so no stall leaks around reset.
        stall  = reset && ex_q.mem_read && (rn_hit_ex || rm_hit_ex);
        squash = stall || bus.FlushID;

        if (!squash) begin
            ex_d   = '{rd:        bus.WriteRegID,
                       reg_write: bus.RegWriteRegisterID,
                       mem_read:  bus.MemReadRegisterID};
            fwd1_d = pick_sel(rn_hit_ex, rn_hit_mem, mem_q.mem_read);
            fwd2_d = pick_sel(rm_hit_ex, rm_hit_mem, mem_q.mem_read);
        end
        bubble_d = squash;
    end

    // Shadow slots shift EX->MEM->WB every clock; selects are registered for EX.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so the shift reads old values.
        if (!reset) begin
            ex_q     <= SLOT_BUBBLE;
            mem_q    <= SLOT_BUBBLE;
            wb_q     <= SLOT_BUBBLE;
            fwd1_q   <= FWD_REG;
            fwd2_q   <= FWD_REG;
            bubble_q <= 1'b1;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            fwd1_q   <= fwd1_d;
            fwd2_q   <= fwd2_d;
            bubble_q <= bubble_d;
        end
    end

    // The WB slot never selects a forward (register file writes before it reads);
    // it is kept as a shadow of the WB stage and checked to track MEM faithfully.
    wb_tracks_mem: assert property (@(posedge clk) reset |=> (wb_q == $past(mem_q)));

    assign bus.ForwCntrl1 = fwd1_q;
    assign bus.ForwCntrl2 = fwd2_q;
    assign bus.BubbleEX   = bubble_q;
    assign bus.StallID    = stall;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit. Each stimulus row pushes its expected
// stall (same cycle) and expected registered outputs (next cycle) into a queue;
// a negedge monitor pops and compares them as the cycles come due.
module tb_forward_hazard_unit;
    import pipe_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    forward_hazard_unit_if bus();

    forward_hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        int         due;
        int         row;
        logic       is_reg;
        logic       stall;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       bub;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int row,
                         input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0b, expected %0b", name, row, act, exp);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed row %0d: due cycle %0d, now %0d", e.row, e.due, cyc);
            end else if (e.is_reg) begin
                check("ForwCntrl1", e.row, bus.ForwCntrl1, e.f1);
                check("ForwCntrl2", e.row, bus.ForwCntrl2, e.f2);
                check("BubbleEX",   e.row, {1'b0, bus.BubbleEX}, {1'b0, e.bub});
            end else begin
                check("StallID",    e.row, {1'b0, bus.StallID}, {1'b0, e.stall});
            end
        end
    end

    // Drive one ID-stage instruction for one cycle and queue its expectations.
    task automatic step(input int row, input logic rst,
                        input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm,
                        input logic [4:0] wr, input logic rw, input logic mr,
                        input logic fl,
                        input logic e_stall, input logic [1:0] e_f1,
                        input logic [1:0] e_f2, input logic e_bub);
        @(posedge clk);
        #1;
        reset                  = rst;
        bus.RnID               = rn;
        bus.RmID               = rm;
        bus.UsesRnID           = urn;
        bus.UsesRmID           = urm;
        bus.WriteRegID         = wr;
        bus.RegWriteRegisterID = rw;
        bus.MemReadRegisterID  = mr;
        bus.FlushID            = fl;
        exp_q.push_back('{due: cyc, row: row, is_reg: 1'b0, stall: e_stall,
                          f1: 2'b00, f2: 2'b00, bub: 1'b0});
        exp_q.push_back('{due: cyc + 1, row: row, is_reg: 1'b1, stall: 1'b0,
                          f1: e_f1, f2: e_f2, bub: e_bub});
    endtask

    initial begin
        bus.RnID               = 5'd31;
        bus.RmID               = 5'd31;
        bus.UsesRnID           = 1'b0;
        bus.UsesRmID           = 1'b0;
        bus.WriteRegID         = 5'd31;
        bus.RegWriteRegisterID = 1'b0;
        bus.MemReadRegisterID  = 1'b0;
        bus.FlushID            = 1'b0;

        //    row rst  rn  rm urn urm  wr rw mr fl  stall f1 f2 bub
        // Reset: bubble state; a load presented during reset must not stall.
        step( 0, 0, 31, 31, 0, 0, 31, 0, 0, 0,   0, 0, 0, 1);
        step( 1, 0,  5,  5, 1, 1,  5, 1, 1, 0,   0, 0, 0, 1);
        // ADD X1,X2,X3 ; SUB X4,X1,X5 -> Rn from EX slot
        step( 2, 1,  2,  3, 1, 1,  1, 1, 0, 0,   0, 0, 0, 0);
        step( 3, 1,  1,  5, 1, 1,  4, 1, 0, 0,   0, 1, 0, 0);
        // ADD X1 ; NOP ; ORR X6,X7,X1 -> Rm from MEM slot (WB result)
        step( 4, 1,  2,  3, 1, 1,  1, 1, 0, 0,   0, 0, 0, 0);
        step( 5, 1, 31, 31, 0, 0, 31, 0, 0, 0,   0, 0, 0, 0);
        step( 6, 1,  7,  1, 1, 1,  6, 1, 0, 0,   0, 0, 2, 0);
        // LDUR X9 ; ADD X10,X9,X9 -> stall, bubble, then 01/01
        step( 7, 1,  2,  0, 1, 0,  9, 1, 1, 0,   0, 0, 0, 0);
        step( 8, 1,  9,  9, 1, 1, 10, 1, 0, 0,   1, 0, 0, 1);
        step( 9, 1,  9,  9, 1, 1, 10, 1, 0, 0,   0, 1, 1, 0);
        // ADD X31 ; ADD X3,X31,X31 -> XZR never forwarded
        step(10, 1,  1,  2, 1, 1, 31, 1, 0, 0,   0, 0, 0, 0);
        step(11, 1, 31, 31, 1, 1,  3, 1, 0, 0,   0, 0, 0, 0);
        // ADD X1 twice ; reader of X1 -> newer producer wins (01)
        step(12, 1,  4,  5, 1, 1,  1, 1, 0, 0,   0, 0, 0, 0);
        step(13, 1,  4,  5, 1, 1,  1, 1, 0, 0,   0, 0, 0, 0);
        step(14, 1,  1,  1, 1, 1,  2, 1, 0, 0,   0, 1, 1, 0);
        // Load-use with FlushID -> bubble; flushed ADD X8 never becomes a producer
        step(15, 1,  4,  0, 1, 0,  7, 1, 1, 0,   0, 0, 0, 0);
        step(16, 1,  7,  7, 1, 1,  8, 1, 0, 1,   1, 0, 0, 1);
        step(17, 1,  8,  8, 1, 1, 11, 1, 0, 0,   0, 0, 0, 0);
        // Reset during a load-use cycle -> no stall, selects 00, bubble; none carried out
        step(18, 1,  3,  0, 1, 0, 12, 1, 1, 0,   0, 0, 0, 0);
        step(19, 0, 12,  0, 1, 1, 13, 1, 0, 0,   0, 0, 0, 1);
        step(20, 1, 12,  0, 1, 1, 13, 1, 0, 0,   0, 0, 0, 0);
        // Producer only in the WB slot -> no select
        step(21, 1, 31, 31, 0, 0, 31, 0, 0, 0,   0, 0, 0, 0);
        step(22, 1, 31, 31, 0, 0, 31, 0, 0, 0,   0, 0, 0, 0);
        step(23, 1, 13, 13, 1, 1, 14, 1, 0, 0,   0, 0, 0, 0);
        // Load-use on Rm only (store data) -> stall, then Rm from loaded value
        step(24, 1,  2,  0, 1, 0, 15, 1, 1, 0,   0, 0, 0, 0);
        step(25, 1,  3, 15, 1, 1, 31, 0, 0, 0,   1, 0, 0, 1);
        step(26, 1,  3, 15, 1, 1, 31, 0, 0, 0,   0, 0, 1, 0);
        // Drain
        step(27, 1, 31, 31, 0, 0, 31, 0, 0, 0,   0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
